// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit sequencer.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_t;

    localparam logic [7:0]  SYNC_BYTE    = 8'h80;
    localparam int unsigned EOP_SE0_BITS = 2;
    localparam int unsigned EOP_J_BITS   = 1;

endpackage

// File: rtl/usb_tx_sequencer_bit_timer.sv
// USB bit-time divider: emits a one-cycle strobe every CLK_DIV enabled clocks.
module usb_bit_timer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic clk12_o
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          wrap;

    assign wrap    = (div_q == DW'(CLK_DIV - 1));
    assign clk12_o = en_i && !clr_i && wrap;

    always_comb begin
        div_d = div_q;
        if (clr_i || !en_i) begin
            div_d = '0;
        end else if (wrap) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/usb_tx_sequencer.sv
// USB transmit sequencer: SYNC + LSB-first bytes with bit stuffing, then EOP,
// presented to the NRZI encoder as registered per-slot controls.
module usb_tx_sequencer
    import usb_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned STUFF_LIMIT = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    input  logic       tx_last,
    output logic       tx_data_ready,
    output logic       clk12,
    output logic       serial_out,
    output logic       enc_en,
    output logic       bit_stuff_en,
    output logic       eop_en,
    output logic       eop_reset,
    output logic       bytecomplete,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_underrun
);

    localparam int unsigned OW = $clog2(STUFF_LIMIT + 1);

    tx_state_t      state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     idx_q, idx_d;
    logic [OW-1:0]  ones_q, ones_d;
    logic           last_q, last_d;
    logic           stuff_q, stuff_d;
    logic [1:0]     eop_cnt_q, eop_cnt_d;
    logic           serial_q, serial_d;
    logic           enc_q, enc_d;
    logic           eop_en_q, eop_en_d;
    logic           eop_rst_q, eop_rst_d;
    logic           start_acc;
    logic           advance;

    assign start_acc = tx_start && (state_q == ST_IDLE);

    usb_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (start_acc),
        .en_i    (state_q != ST_IDLE),
        .clk12_o (clk12)
    );

    assign serial_out   = serial_q;
    assign enc_en       = enc_q;
    assign bit_stuff_en = stuff_q;
    assign eop_en       = eop_en_q;
    assign eop_reset    = eop_rst_q;
    assign tx_busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        idx_d         = idx_q;
        ones_d        = ones_q;
        last_d        = last_q;
        stuff_d       = stuff_q;
        eop_cnt_d     = eop_cnt_q;
        serial_d      = serial_q;
        enc_d         = enc_q;
        eop_en_d      = eop_en_q;
        eop_rst_d     = eop_rst_q;
        advance       = 1'b0;
        tx_data_ready = 1'b0;
        bytecomplete  = 1'b0;
        tx_underrun   = 1'b0;
        tx_done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    state_d  = ST_SYNC;
                    shift_d  = SYNC_BYTE;
                    idx_d    = '0;
                    ones_d   = '0;
                    last_d   = 1'b0;
                    stuff_d  = 1'b0;
                    serial_d = SYNC_BYTE[0];
                    enc_d    = 1'b1;
                end
            end

            ST_SYNC, ST_DATA: begin
                if (clk12) begin
                    // A stuff slot defers the pending shift/boundary action to its own closing strobe.
                    if (stuff_q) begin
                        stuff_d = 1'b0;
                        ones_d  = '0;
                        advance = 1'b1;
                    end else if (shift_q[0] && (ones_q == OW'(STUFF_LIMIT - 1))) begin
                        stuff_d  = 1'b1;
                        ones_d   = '0;
                        serial_d = 1'b0;
                        enc_d    = 1'b0;
                    end else begin
                        ones_d  = shift_q[0] ? ones_q + OW'(1) : '0;
                        advance = 1'b1;
                    end

                    if (advance) begin
                        enc_d = 1'b1;
                        if (idx_q != 3'd7) begin
                            shift_d  = {1'b0, shift_q[7:1]};
                            idx_d    = idx_q + 3'd1;
                            serial_d = shift_q[1];
                        end else begin
                            bytecomplete = 1'b1;
                            if (!last_q && tx_data_valid) begin
                                tx_data_ready = 1'b1;
                                state_d       = ST_DATA;
                                shift_d       = tx_data;
                                last_d        = tx_last;
                                idx_d         = '0;
                                serial_d      = tx_data[0];
                            end else begin
                                tx_underrun = !last_q;
                                state_d     = ST_EOP_SE0;
                                eop_cnt_d   = '0;
                                serial_d    = 1'b1;
                                enc_d       = 1'b0;
                                eop_en_d    = 1'b1;
                            end
                        end
                    end
                end
            end

            ST_EOP_SE0: begin
                if (clk12) begin
                    if (eop_cnt_q == 2'(EOP_SE0_BITS - 1)) begin
                        state_d   = ST_EOP_J;
                        eop_cnt_d = '0;
                        eop_en_d  = 1'b0;
                        eop_rst_d = 1'b1;
                    end else begin
                        eop_cnt_d = eop_cnt_q + 2'd1;
                    end
                end
            end

            ST_EOP_J: begin
                if (clk12) begin
                    if (eop_cnt_q == 2'(EOP_J_BITS - 1)) begin
                        state_d   = ST_IDLE;
                        tx_done   = 1'b1;
                        eop_cnt_d = '0;
                        serial_d  = 1'b1;
                        eop_rst_d = 1'b0;
                    end else begin
                        eop_cnt_d = eop_cnt_q + 2'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            ones_q    <= '0;
            last_q    <= 1'b0;
            stuff_q   <= 1'b0;
            eop_cnt_q <= '0;
            serial_q  <= 1'b1;
            enc_q     <= 1'b0;
            eop_en_q  <= 1'b0;
            eop_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            ones_q    <= ones_d;
            last_q    <= last_d;
            stuff_q   <= stuff_d;
            eop_cnt_q <= eop_cnt_d;
            serial_q  <= serial_d;
            enc_q     <= enc_d;
            eop_en_q  <= eop_en_d;
            eop_rst_q <= eop_rst_d;
        end
    end

endmodule
